elastic_reg_pipe: RTL and testbench

//   Parametrised elastic register pipeline: WIDTH-bit words through DEPTH register stages.

---
 rtl/elastic_reg_pipe.sv | 88 ++++++++
 tb/tb_elastic_reg_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/elastic_reg_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with a collapsing ready chain,
// synchronous flush and a registered occupancy count.
module elastic_reg_pipe #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           DEPTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer, out_xfer;

  // rdy[i] = ~vld[i] | rdy[i+1], unrolled with a running term to keep the chain acyclic
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      r = r | ~vld_q[DEPTH-1-j];
      rdy[DEPTH-1-j] = r;
    end
  end

  assign in_ready  = rdy[0] & ~flush & ~rst;
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
  assign count     = count_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (rdy[0]) begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dat_q[i] <= RESET_VAL;
      end
    end else if (flush) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Bench for elastic_reg_pipe: directed scenarios plus a random stream, checked every
// cycle against a word-queue model where the head word shows after DEPTH-1 edges.
module tb_elastic_reg_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;

  elastic_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words in acceptance order, each stamped with the edge that accepted it.
  logic [WIDTH-1:0] mq [$];
  int               ms [$];
  int               ecount   = 0;
  bit               model_on = 0;

  function automatic bit m_out_valid();
    return (mq.size() > 0) && ((ecount - ms[0]) >= int'(DEPTH) - 1);
  endfunction

  function automatic bit m_in_ready();
    return !rst && !flush && ((mq.size() < int'(DEPTH)) || out_ready);
  endfunction

  always @(posedge clk) begin
    bit ov, ir;
    ov = m_out_valid();
    ir = m_in_ready();
    ecount++;
    if (rst) begin
      mq.delete(); ms.delete();
      model_on = 1;
    end else if (flush) begin
      mq.delete(); ms.delete();
    end else begin
      if (ov && out_ready) begin
        void'(mq.pop_front()); void'(ms.pop_front());
      end
      if (in_valid && ir) begin
        mq.push_back(in_data); ms.push_back(ecount);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, m_out_valid());
      chk("count", count, mq.size());
      if (m_out_valid()) chk("out_data", out_data, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk("send_timeout", n < 200, 1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_count", count, 0);

    // 1: three contiguous words, first visible on the 4th edge from acceptance
    out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    chk("t1_count_peak", count, 3);
    chk("t1_not_yet", out_valid, 0);
    step();
    chk("t1_lat_valid", out_valid, 1);
    chk("t1_lat_data", out_data, 8'h11);
    repeat (6) step();

    // 2: stalled consumer fills the pipe, then drains in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    in_valid = 1'b1; in_data = 8'hA4;
    #1;
    chk("t2_full_count", count, 4);
    chk("t2_full_ready", in_ready, 0);
    repeat (2) step();
    out_ready = 1'b1;
    send(8'hA4); send(8'hA5);
    repeat (8) step();

    // 3: full pipe with both sides active
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      #1;
      chk("t3_count", count, 4);
      chk("t3_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();

    // 4: flush drops held words and refuses the word offered alongside it
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hD0 + 8'(i));
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    chk("t4_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_count", count, 0);
    chk("t4_out_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_no_5A", out_valid && out_data == 8'h5A, 0);
      step();
    end

    // 5: reset wins over flush and input
    out_ready = 1'b0;
    send(8'hE0); send(8'hE1);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    chk("t5_in_ready_rst", in_ready, 0);
    step();
    chk("t5_count", count, 0);
    chk("t5_out_data", out_data, 8'h00);
    chk("t5_out_valid", out_valid, 0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_in_ready", in_ready, 1);
    step();

    // 6: random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("t6_drained", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
